// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one- or two-word instructions from IRAM,
// splits them into decoder fields and issues them with a valid/ready
// handshake. Jump requests from execute redirect the fetch stream.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  output logic [1:0]  Control,
  output logic [15:0] InstrAddr,
  input  logic [15:0] InstrIn,
  output logic        FetchValid,
  input  logic        FetchReady,
  output logic [3:0]  Opcode,
  output logic [4:0]  OperandA,
  output logic [4:0]  OperandB,
  output logic [15:0] Immediate,
  output logic        HasImm,
  input  logic        JumpEn,
  input  logic [15:0] JumpAddr,
  output logic        Halted
);

  localparam logic [1:0] CtlIdle = 2'd0;
  localparam logic [1:0] CtlRead = 2'd1;
  localparam logic [3:0] OpEnd   = 4'd1;
  localparam logic [3:0] OpLoad  = 4'd4;
  localparam logic [3:0] OpJmpz  = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapt,
    StFetchImm,
    StCaptImm,
    StIssue,
    StHalt
  } state_e;

  state_e      state;
  logic [15:0] pc;

  // Bits [1:0] of the instruction word carry no field.
  logic unused_instr_bits;
  assign unused_instr_bits = ^InstrIn[1:0];

  // Fetch sequencing, field capture and issue handshake; all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      pc         <= RESET_PC;
      InstrAddr  <= RESET_PC;
      Control    <= CtlIdle;
      FetchValid <= 1'b0;
      Opcode     <= 4'd0;
      OperandA   <= 5'd0;
      OperandB   <= 5'd0;
      Immediate  <= 16'd0;
      HasImm     <= 1'b0;
      Halted     <= 1'b0;
    end else if (JumpEn && (state != StIdle) && (state != StHalt)) begin
      // Redirect wins over everything, including a handshake on this edge;
      // any fetch in flight is abandoned and its data never latched.
      state      <= StFetch;
      pc         <= JumpAddr;
      InstrAddr  <= JumpAddr;
      Control    <= CtlRead;
      FetchValid <= 1'b0;
      Opcode     <= 4'd0;
      OperandA   <= 5'd0;
      OperandB   <= 5'd0;
      Immediate  <= 16'd0;
      HasImm     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (Start) begin
            state     <= StFetch;
            InstrAddr <= pc;
            Control   <= CtlRead;
          end
        end
        StFetch: begin
          state   <= StCapt;
          Control <= CtlIdle;
        end
        StCapt: begin
          Opcode   <= InstrIn[15:12];
          OperandA <= InstrIn[11:7];
          OperandB <= InstrIn[6:2];
          pc       <= pc + 16'd1;
          if ((InstrIn[15:12] == OpLoad) || (InstrIn[15:12] == OpJmpz)) begin
            state     <= StFetchImm;
            InstrAddr <= pc + 16'd1;
            Control   <= CtlRead;
          end else begin
            state      <= StIssue;
            FetchValid <= 1'b1;
          end
        end
        StFetchImm: begin
          state   <= StCaptImm;
          Control <= CtlIdle;
        end
        StCaptImm: begin
          Immediate  <= InstrIn;
          HasImm     <= 1'b1;
          pc         <= pc + 16'd1;
          state      <= StIssue;
          FetchValid <= 1'b1;
        end
        StIssue: begin
          if (FetchReady) begin
            FetchValid <= 1'b0;
            HasImm     <= 1'b0;
            Immediate  <= 16'd0;
            if (Opcode == OpEnd) begin
              state   <= StHalt;
              Halted  <= 1'b1;
              Control <= CtlIdle;
            end else begin
              state     <= StFetch;
              InstrAddr <= pc;
              Control   <= CtlRead;
            end
          end
        end
        StHalt: begin
          Control <= CtlIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
